truth_table_scanner: RTL and testbench



---
 rtl/truth_table_scanner.sv | 155 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Self-timed truth-table sweeper: drives every input code, waits SETTLE cycles, samples f_in.
// Optional golden-table comparator built only when TRUTH_TABLE_COMPARE_EN is defined.
module truth_table_scanner #(
  parameter int                    WIDTH    = 4,
  parameter int                    SETTLE   = 1,
  parameter logic [(2**WIDTH)-1:0] EXPECTED = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [WIDTH-1:0]        code,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic [(2**WIDTH)-1:0]   table_out,
  output logic [WIDTH:0]          ones,
  output logic                    mismatch
);

  localparam int N  = 2**WIDTH;
  localparam int OW = WIDTH + 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic [WIDTH-1:0] code_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     table_r;
  logic [OW-1:0]    ones_r;
  logic [N-1:0]     table_next_s;
  logic             sample_s;
  logic             last_s;

  assign sample_s  = (state_r == S_WAIT) && (cnt_r == {CW{1'b0}});
  assign last_s    = (code_r == {WIDTH{1'b1}});
  assign code      = code_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign table_out = table_r;
  assign ones      = ones_r;

  // State register; busy/done are registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_WAIT;
        else       state_s = S_IDLE;
      end
      S_WAIT: begin
        if (sample_s && last_s) state_s = S_DONE;
        else                    state_s = S_WAIT;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      S_IDLE: begin busy_s = 1'b0; done_s = 1'b0; end
      S_WAIT: begin busy_s = 1'b1; done_s = 1'b0; end
      S_DONE: begin busy_s = 1'b0; done_s = 1'b1; end
      default: begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Table with the current sample merged in; also feeds the final comparison
  always_comb begin
    table_next_s         = table_r;
    table_next_s[code_r] = f_in;
  end

  // Sweep datapath: code stepping, settle countdown, capture and ones count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      table_r <= {N{1'b0}};
      ones_r  <= {OW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            code_r  <= {WIDTH{1'b0}};
            cnt_r   <= CW'(SETTLE);
            table_r <= {N{1'b0}};
            ones_r  <= {OW{1'b0}};
          end
        end
        S_WAIT: begin
          if (!sample_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            table_r <= table_next_s;
            ones_r  <= ones_r + OW'(f_in);
            if (!last_s) begin
              code_r <= code_r + WIDTH'(1);
              cnt_r  <= CW'(SETTLE);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_COMPARE_EN
  logic mismatch_r;

  // Golden compare on the final sample; cleared on accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r <= 1'b0;
    end else if ((state_r == S_IDLE) && start) begin
      mismatch_r <= 1'b0;
    end else if (sample_s && last_s) begin
      mismatch_r <= (table_next_s != EXPECTED);
    end
  end

  assign mismatch = mismatch_r;
`else
  localparam logic expected_unused = ^EXPECTED;
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=0), directed and random tables.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [3:0]  code_a, code_b, code_a_d;
  logic        f_a, f_b, noise;
  logic        busy_a, busy_b, done_a, done_b, mm_a, mm_b;
  logic [15:0] table_a, table_b;
  logic [4:0]  ones_a, ones_b;

  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  logic [15:0] rand_tbl = 16'h0000;
  bit          sel = 1'b0;

  logic [3:0]  code_m;
  logic        busy_m, done_m, mm_m;
  logic [15:0] table_m;
  logic [4:0]  ones_m;

  always #5 clk = ~clk;

  function automatic logic fn(input int m, input logic [3:0] c, input logic [15:0] t);
    case (m)
      0:       return ^c;
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (c == 4'd5);
      default: return t[c];
    endcase
  endfunction

  // f_a carries random noise in the first cycle of each code; only the settled value may be captured
  always @(posedge clk) begin
    noise    <= 1'($urandom);
    code_a_d <= code_a;
  end
  assign f_a = (code_a != code_a_d) ? noise : fn(mode, code_a, rand_tbl);
  assign f_b = fn(mode, code_b, rand_tbl);

  always_comb begin
    code_m  = sel ? code_b  : code_a;
    busy_m  = sel ? busy_b  : busy_a;
    done_m  = sel ? done_b  : done_a;
    mm_m    = sel ? mm_b    : mm_a;
    table_m = sel ? table_b : table_a;
    ones_m  = sel ? ones_b  : ones_a;
  end

  truth_table_scanner #(.WIDTH(4), .SETTLE(1), .EXPECTED(16'h6996)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .code(code_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .table_out(table_a), .ones(ones_a), .mismatch(mm_a)
  );

  truth_table_scanner #(.WIDTH(4), .SETTLE(0), .EXPECTED(16'h6996)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .code(code_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .table_out(table_b), .ones(ones_b), .mismatch(mm_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // One full scan; inject re-pulses start mid-scan and in the done cycle
  task automatic run_scan(input bit sel_i, input int mode_i, input bit inject, input string tag);
    logic [15:0] exp_tbl;
    logic [4:0]  exp_ones;
    logic        exp_mm;
    int          hold, span, done_at;
    sel  = sel_i;
    mode = mode_i;
    exp_ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      exp_tbl[i] = fn(mode_i, 4'(i), rand_tbl);
      exp_ones   = exp_ones + 5'(exp_tbl[i]);
    end
`ifdef TRUTH_TABLE_COMPARE_EN
    exp_mm = (exp_tbl != 16'h6996);
`else
    exp_mm = 1'b0;
`endif
    hold = sel_i ? 1 : 2;
    span = 16 * hold;
    done_at = -1;
    drive_start(1'b1);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      drive_start(inject && (c == 5 || c == 20));
      if (done_m) begin
        done_at = c;
        break;
      end
      check({tag, "_code"}, 32'(code_m), 32'(c / hold));
      check({tag, "_busy"}, 32'(busy_m), 32'd1);
    end
    check({tag, "_done_at"}, done_at, span);
    check({tag, "_table"}, 32'(table_m), 32'(exp_tbl));
    check({tag, "_ones"}, 32'(ones_m), 32'(exp_ones));
    check({tag, "_mismatch"}, 32'(mm_m), 32'(exp_mm));
    check({tag, "_busy_done"}, 32'(busy_m), 32'd0);
    if (inject) drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy_m), 32'd0);
    check({tag, "_code_hold"}, 32'(code_m), 32'd15);
    check({tag, "_table_hold"}, 32'(table_m), 32'(exp_tbl));
    check({tag, "_ones_hold"}, 32'(ones_m), 32'(exp_ones));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"}, 32'(code_m), 32'd0);
    check({tag, "_busy"}, 32'(busy_m), 32'd0);
    check({tag, "_done"}, 32'(done_m), 32'd0);
    check({tag, "_table"}, 32'(table_m), 32'd0);
    check({tag, "_ones"}, 32'(ones_m), 32'd0);
    check({tag, "_mismatch"}, 32'(mm_m), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_zero("rst_a");
    sel = 1'b1; #1; check_zero("rst_b");
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(1'b0, 0, 1'b0, "parity");
    run_scan(1'b0, 1, 1'b0, "all_ones");
    run_scan(1'b0, 2, 1'b0, "all_zeros");
    run_scan(1'b1, 3, 1'b0, "s0_code5");
    run_scan(1'b0, 0, 1'b1, "restart_ign");
    run_scan(1'b0, 3, 1'b0, "after_ign");
    for (int k = 0; k < 4; k++) begin
      rand_tbl = 16'($urandom);
      run_scan(1'(k & 1), 4, 1'b0, "random");
    end

    // Asynchronous reset in the middle of a scan
    sel = 1'b0;
    mode = 0;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (code_a == 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midscan_reached7", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midscan_rst");
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    check("midscan_no_done", 32'(seen), 32'd0);
    check_zero("midscan_idle");
    run_scan(1'b0, 0, 1'b0, "post_rst");
    rand_tbl = 16'($urandom);
    run_scan(1'b1, 4, 1'b0, "post_rst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
